// File: rtl/stream_gen_pkg.sv
// Shared types, constants and helpers for the stream packet generator.
package stream_gen_pkg;

  localparam int unsigned LANE_W    = 32;
  localparam int unsigned MAX_PHIT  = 2048;
  localparam int unsigned MAX_LANES = MAX_PHIT / LANE_W;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
    GAP,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_FLOAT = 2'd1,
    MODE_LFSR  = 2'd2
  } mode_e;

  // Copy one 32-bit word into the lowest 'lanes' lanes; callers truncate to their width.
  function automatic logic [MAX_PHIT-1:0] lane_replicate(input logic [31:0] w,
                                                         input int unsigned lanes);
    logic [MAX_PHIT-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < lanes) r[i*LANE_W +: LANE_W] = w;
    end
    return r;
  endfunction

  // One Galois step, shifting right with feedback from bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // Float pattern: the 5-bit beat index encoded as an IEEE-754 single.
  function automatic logic [31:0] float_generator(input logic [4:0] idx);
    logic [22:0] man;
    logic [7:0]  expo;
    int          msb;
    msb  = 0;
    man  = '0;
    expo = '0;
    for (int i = 0; i < 5; i++) begin
      if (idx[i]) msb = i;
    end
    if (idx != 5'd0) begin
      expo = 8'(127 + msb);
      man  = {18'b0, idx};
      man  = man << (23 - msb);
    end
    return {1'b0, expo, man};
  endfunction

endpackage

// File: rtl/stream_rx_checker.sv
// RX sink bookkeeping: beat/packet counters and sticky framing error.
module stream_rx_checker
  import stream_gen_pkg::*;
#(
  parameter int unsigned PKT_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid_i,
  input  logic        rx_ready_i,
  input  logic        rx_last_i,
  output logic [31:0] pkt_count_o,
  output logic [31:0] beat_count_o,
  output logic        err_o
);

  localparam logic [31:0] LAST_BEAT = 32'(PKT_LEN - 1);

  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] bip_q, bip_d;
  logic        err_q, err_d;
  logic        hs_c;

  // Count handshakes and check each packet closes on exactly PKT_LEN beats.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    beat_cnt_d = beat_cnt_q;
    bip_d      = bip_q;
    err_d      = err_q;
    hs_c       = rx_valid_i & rx_ready_i;
    if (hs_c) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (rx_last_i) begin
        pkt_cnt_d = pkt_cnt_q + 32'd1;
        bip_d     = '0;
        if (bip_q != LAST_BEAT) err_d = 1'b1;
      end else if (bip_q == LAST_BEAT) begin
        // Overlong packet: flag it and resynchronise the beat counter.
        err_d = 1'b1;
        bip_d = '0;
      end else begin
        bip_d = bip_q + 32'd1;
      end
    end
  end

  // Counter and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
      bip_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      bip_q      <= bip_d;
      err_q      <= err_d;
    end
  end

  assign pkt_count_o  = pkt_cnt_q;
  assign beat_count_o = beat_cnt_q;
  assign err_o        = err_q;

endmodule

// File: rtl/stream_pkt_gen.sv
// AXI-Stream packet generator (TX) with loopback framing checker (RX).
module stream_pkt_gen
  import stream_gen_pkg::*;
#(
  parameter int unsigned PHIT_SIZE  = 512,
  parameter int unsigned PKT_LEN    = 16,
  parameter int unsigned NUM_PKTS   = 0,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned MODE       = 0,
  parameter logic [31:0] HEADER     = 32'h1234_5678,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            tx_pkt_count,
  output logic [PHIT_SIZE-1:0]   axis00_tdata,
  output logic                   axis00_tvalid,
  input  logic                   axis00_tready,
  output logic                   axis00_tlast,
  output logic [PHIT_SIZE/8-1:0] axis00_tkeep,
  input  logic [PHIT_SIZE-1:0]   axis01_tdata,
  input  logic                   axis01_tvalid,
  output logic                   axis01_tready,
  input  logic                   axis01_tlast,
  input  logic [PHIT_SIZE/8-1:0] axis01_tkeep,
  input  logic                   rx_ready,
  output logic [31:0]            rx_pkt_count,
  output logic [31:0]            rx_beat_count,
  output logic                   rx_err
);

  localparam int unsigned KEEP_W    = PHIT_SIZE / 8;
  localparam int unsigned LANES     = PHIT_SIZE / LANE_W;
  localparam logic [31:0] LAST_BEAT = 32'(PKT_LEN - 1);
  localparam logic [31:0] LAST_GAP  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] NUM_P     = 32'(NUM_PKTS);
  localparam mode_e       PAT       = mode_e'(2'(MODE));

  state_e                state_q, state_d;
  logic [31:0]           pkt_idx_q, pkt_idx_d;
  logic [31:0]           beat_idx_q, beat_idx_d;
  logic [31:0]           gap_cnt_q, gap_cnt_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [31:0]           tx_cnt_q, tx_cnt_d;
  logic                  abort_seen_q, abort_seen_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [PHIT_SIZE-1:0]  tdata_q, tdata_d;
  logic                  tx_hs_c;
  logic [31:0]           word_c;
  logic                  unused_rx_c;

  // Next-state logic; output registers are loaded from the next state so the
  // beat on the bus is stable until it is handshaked.
  always_comb begin
    state_d      = state_q;
    pkt_idx_d    = pkt_idx_q;
    beat_idx_d   = beat_idx_q;
    gap_cnt_d    = gap_cnt_q;
    lfsr_d       = lfsr_q;
    tx_cnt_d     = tx_cnt_q;
    abort_seen_d = abort_seen_q;
    tx_hs_c      = tvalid_q & axis00_tready;
    word_c       = '0;
    tdata_d      = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = HDR;
          pkt_idx_d    = '0;
          beat_idx_d   = '0;
          tx_cnt_d     = '0;
          lfsr_d       = LFSR_SEED;
          abort_seen_d = abort;
        end
      end
      HDR: begin
        abort_seen_d = abort_seen_q | abort;
        if (tx_hs_c) begin
          state_d    = PAY;
          beat_idx_d = 32'd1;
        end
      end
      PAY: begin
        abort_seen_d = abort_seen_q | abort;
        if (tx_hs_c) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (beat_idx_q == LAST_BEAT) begin
            beat_idx_d = '0;
            pkt_idx_d  = pkt_idx_q + 32'd1;
            tx_cnt_d   = tx_cnt_q + 32'd1;
            if ((NUM_PKTS != 0 && (pkt_idx_q + 32'd1) == NUM_P) ||
                abort_seen_q || abort) begin
              state_d = DONE;
            end else if (GAP_CYCLES > 0) begin
              state_d      = GAP;
              gap_cnt_d    = '0;
              abort_seen_d = 1'b0;
            end else begin
              state_d      = HDR;
              abort_seen_d = 1'b0;
            end
          end else begin
            beat_idx_d = beat_idx_q + 32'd1;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = DONE;
        end else if (gap_cnt_q == LAST_GAP) begin
          state_d = HDR;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tvalid_d = (state_d == HDR) || (state_d == PAY);
    tlast_d  = (state_d == PAY) && (beat_idx_d == LAST_BEAT);
    busy_d   = (state_d == HDR) || (state_d == PAY) || (state_d == GAP);
    done_d   = (state_d == DONE);

    unique case (PAT)
      MODE_RAMP:  word_c = {pkt_idx_d[15:0], beat_idx_d[15:0]};
      MODE_FLOAT: word_c = float_generator(beat_idx_d[4:0]);
      default:    word_c = lfsr_d;
    endcase

    if (state_d == HDR) begin
      tdata_d[31:0]  = HEADER;
      tdata_d[63:32] = pkt_idx_d;
    end else if (state_d == PAY) begin
      tdata_d = PHIT_SIZE'(lane_replicate(word_c, LANES));
    end
  end

  // State and registered TX outputs; reset drops tvalid immediately.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= IDLE;
      pkt_idx_q    <= '0;
      beat_idx_q   <= '0;
      gap_cnt_q    <= '0;
      lfsr_q       <= LFSR_SEED;
      tx_cnt_q     <= '0;
      abort_seen_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      pkt_idx_q    <= pkt_idx_d;
      beat_idx_q   <= beat_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      lfsr_q       <= lfsr_d;
      tx_cnt_q     <= tx_cnt_d;
      abort_seen_q <= abort_seen_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tdata_q      <= tdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign tx_pkt_count  = tx_cnt_q;
  assign axis00_tdata  = tdata_q;
  assign axis00_tvalid = tvalid_q;
  assign axis00_tlast  = tlast_q;
  assign axis00_tkeep  = {KEEP_W{tvalid_q}};

  // RX payload and keep are not inspected, only framing.
  assign unused_rx_c   = ^{axis01_tdata, axis01_tkeep};
  assign axis01_tready = rx_ready;

  stream_rx_checker #(
    .PKT_LEN(PKT_LEN)
  ) u_rx_checker (
    .clk          (ap_clk),
    .rst_n        (ap_rst_n),
    .rx_valid_i   (axis01_tvalid),
    .rx_ready_i   (rx_ready),
    .rx_last_i    (axis01_tlast),
    .pkt_count_o  (rx_pkt_count),
    .beat_count_o (rx_beat_count),
    .err_o        (rx_err)
  );

endmodule
